// File: rtl/switch_debounce_pkg.sv
// Board constants shared by the switch conditioning logic.
package switch_debounce_pkg;

  localparam int CLK_HZ      = 50_000_000;
  localparam int DEBOUNCE_MS = 10;

  // Number of clk cycles in the debounce window.
  function automatic int debounce_cycles(input int clk_hz, input int ms);
    return (clk_hz / 1000) * ms;
  endfunction

endpackage

// File: rtl/switch_debounce_ch.sv
// One debounce channel: 2-FF synchroniser, stability counter, clean level and edge pulses.
module debounce_ch #(
  parameter int CNT_MAX = 4,
  parameter int CNT_W   = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic sw_raw,
  output logic sw_clean,
  output logic sw_rise,
  output logic sw_fall,
  output logic busy
);

  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(CNT_MAX - 1);

  logic             r_s1;
  logic             r_s2;
  logic [CNT_W-1:0] r_cnt;
  logic             r_clean;
  logic             r_rise;
  logic             r_fall;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1    <= 1'b0;
      r_s2    <= 1'b0;
      r_cnt   <= '0;
      r_clean <= 1'b0;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
    end else begin
      r_s1   <= sw_raw;
      r_s2   <= r_s1;
      r_rise <= 1'b0;
      r_fall <= 1'b0;
      if (r_s2 == r_clean) begin
        r_cnt <= '0;
      end else if (r_cnt == C_LAST) begin
        // Level has been stable for the full window: accept it and flag the edge.
        r_clean <= r_s2;
        r_cnt   <= '0;
        r_rise  <= r_s2;
        r_fall  <= ~r_s2;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign sw_clean = r_clean;
  assign sw_rise  = r_rise;
  assign sw_fall  = r_fall;
  assign busy     = (r_cnt != '0);

endmodule

// File: rtl/switch_debounce.sv
// Board-level switch conditioner: NUM_CH independent debounce channels plus a settled flag.
module switch_debounce
  import switch_debounce_pkg::*;
#(
  parameter int NUM_CH  = 3,
  parameter int CNT_MAX = debounce_cycles(CLK_HZ, DEBOUNCE_MS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] sw_raw,
  output logic [NUM_CH-1:0] sw_clean,
  output logic [NUM_CH-1:0] sw_rise,
  output logic [NUM_CH-1:0] sw_fall,
  output logic              settled
);

  localparam int CNT_W = $clog2(CNT_MAX);

  logic [NUM_CH-1:0] w_busy;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    debounce_ch #(
      .CNT_MAX (CNT_MAX),
      .CNT_W   (CNT_W)
    ) u_ch (
      .clk      (clk),
      .rst      (rst),
      .sw_raw   (sw_raw[i]),
      .sw_clean (sw_clean[i]),
      .sw_rise  (sw_rise[i]),
      .sw_fall  (sw_fall[i]),
      .busy     (w_busy[i])
    );
  end

  assign settled = ~|w_busy;

endmodule

// File: tb/tb_switch_debounce.sv
// Directed bench for switch_debounce with a short debounce window (CNT_MAX=4).
module tb_switch_debounce;

  localparam int NUM_CH  = 3;
  localparam int CNT_MAX = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic [NUM_CH-1:0] sw_raw;
  logic [NUM_CH-1:0] sw_clean;
  logic [NUM_CH-1:0] sw_rise;
  logic [NUM_CH-1:0] sw_fall;
  logic              settled;

  int n_vec = 0;
  int n_err = 0;

  switch_debounce #(
    .NUM_CH  (NUM_CH),
    .CNT_MAX (CNT_MAX)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .sw_raw   (sw_raw),
    .sw_clean (sw_clean),
    .sw_rise  (sw_rise),
    .sw_fall  (sw_fall),
    .settled  (settled)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst    = 1'b1;
    sw_raw = '0;
    #23;
    n_vec++;
    if (sw_clean !== 3'b000 || sw_rise !== 3'b000 || sw_fall !== 3'b000 || settled !== 1'b1) begin
      n_err++;
      $display("FAIL reset_state: clean=%b rise=%b fall=%b settled=%b, need 000/000/000/1",
               sw_clean, sw_rise, sw_fall, settled);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_clean_press();
    @(negedge clk);
    sw_raw = 3'b001;
    for (int e = 0; e <= 6; e++) begin
      tick();
      n_vec++;
      if (e == 2 && settled !== 1'b0) begin
        n_err++;
        $display("FAIL press_settled_low e%0d: settled=%b need 0", e, settled);
      end
      if (e < 5 && (sw_clean !== 3'b000 || sw_rise !== 3'b000)) begin
        n_err++;
        $display("FAIL press_early e%0d: clean=%b rise=%b need 000/000", e, sw_clean, sw_rise);
      end
      if (e == 5 && (sw_clean !== 3'b001 || sw_rise !== 3'b001 || sw_fall !== 3'b000)) begin
        n_err++;
        $display("FAIL press_accept e%0d: clean=%b rise=%b fall=%b need 001/001/000",
                 e, sw_clean, sw_rise, sw_fall);
      end
      if (e == 6 && (sw_rise !== 3'b000 || settled !== 1'b1 || sw_clean !== 3'b001)) begin
        n_err++;
        $display("FAIL press_after e%0d: clean=%b rise=%b settled=%b need 001/000/1",
                 e, sw_clean, sw_rise, settled);
      end
    end
  endtask

  task automatic test_release();
    @(negedge clk);
    sw_raw = 3'b000;
    for (int e = 0; e <= 6; e++) begin
      tick();
      n_vec++;
      if (sw_rise !== 3'b000) begin
        n_err++;
        $display("FAIL release_no_rise e%0d: rise=%b need 000", e, sw_rise);
      end
      if (e < 5 && (sw_clean !== 3'b001 || sw_fall !== 3'b000)) begin
        n_err++;
        $display("FAIL release_early e%0d: clean=%b fall=%b need 001/000", e, sw_clean, sw_fall);
      end
      if (e == 5 && (sw_clean !== 3'b000 || sw_fall !== 3'b001)) begin
        n_err++;
        $display("FAIL release_accept e%0d: clean=%b fall=%b need 000/001", e, sw_clean, sw_fall);
      end
      if (e == 6 && (sw_clean !== 3'b000 || sw_fall !== 3'b000)) begin
        n_err++;
        $display("FAIL release_after e%0d: clean=%b fall=%b need 000/000", e, sw_clean, sw_fall);
      end
    end
  endtask

  task automatic test_bounce();
    logic [3:0] pat;
    pat = 4'b0111;
    for (int c = 0; c < 28; c++) begin
      @(negedge clk);
      sw_raw = (c < 20) ? {1'b0, pat[c % 4], 1'b0} : 3'b000;
      tick();
      n_vec++;
      if (sw_clean !== 3'b000 || sw_rise !== 3'b000 || sw_fall !== 3'b000) begin
        n_err++;
        $display("FAIL bounce c%0d: clean=%b rise=%b fall=%b need 000/000/000",
                 c, sw_clean, sw_rise, sw_fall);
      end
    end
    n_vec++;
    if (settled !== 1'b1) begin
      n_err++;
      $display("FAIL bounce_settled: settled=%b need 1", settled);
    end
  endtask

  task automatic test_simultaneous();
    @(negedge clk);
    sw_raw = 3'b101;
    for (int e = 0; e <= 6; e++) begin
      tick();
      n_vec++;
      if (e < 5 && (sw_clean !== 3'b000 || sw_rise !== 3'b000)) begin
        n_err++;
        $display("FAIL simul_early e%0d: clean=%b rise=%b need 000/000", e, sw_clean, sw_rise);
      end
      if (e == 5 && (sw_clean !== 3'b101 || sw_rise !== 3'b101 || sw_fall !== 3'b000)) begin
        n_err++;
        $display("FAIL simul_accept e%0d: clean=%b rise=%b fall=%b need 101/101/000",
                 e, sw_clean, sw_rise, sw_fall);
      end
      if (e == 6 && sw_rise !== 3'b000) begin
        n_err++;
        $display("FAIL simul_after e%0d: rise=%b need 000", e, sw_rise);
      end
    end
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    sw_raw = 3'b111;
    for (int e = 0; e < 8; e++) tick();
    n_vec++;
    if (sw_clean !== 3'b111) begin
      n_err++;
      $display("FAIL async_pre: clean=%b need 111", sw_clean);
    end
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    n_vec++;
    if (sw_clean !== 3'b000 || sw_rise !== 3'b000 || sw_fall !== 3'b000 || settled !== 1'b1) begin
      n_err++;
      $display("FAIL async_reset: clean=%b rise=%b fall=%b settled=%b need 000/000/000/1",
               sw_clean, sw_rise, sw_fall, settled);
    end
    sw_raw = 3'b000;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    sw_raw = 3'b010;
    for (int e = 0; e <= 3; e++) tick();
    @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      tick();
      n_vec++;
      if (sw_clean !== 3'b000 || sw_rise !== 3'b000 || sw_fall !== 3'b000 || settled !== 1'b1) begin
        n_err++;
        $display("FAIL midrst_hold k%0d: clean=%b rise=%b fall=%b settled=%b need 000/000/000/1",
                 k, sw_clean, sw_rise, sw_fall, settled);
      end
    end
    @(negedge clk);
    rst = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      tick();
      n_vec++;
      if (k < 6 && (sw_clean !== 3'b000 || sw_rise !== 3'b000)) begin
        n_err++;
        $display("FAIL midrst_requal k%0d: clean=%b rise=%b need 000/000", k, sw_clean, sw_rise);
      end
      if (k == 6 && (sw_clean !== 3'b010 || sw_rise !== 3'b010)) begin
        n_err++;
        $display("FAIL midrst_accept k%0d: clean=%b rise=%b need 010/010", k, sw_clean, sw_rise);
      end
    end
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_release();
    test_bounce();
    test_simultaneous();
    test_async_reset();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
